// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential double-dabble converter.
package bin2bcd_pkg;

  typedef enum logic {IDLE, SHIFT} b2b_state_t;

  localparam int BCD_NIB_W = 4;

  // Double-dabble pre-shift correction: a nibble of 5 or more gets +3.
  function automatic logic [3:0] add3_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational per-digit adjust applied before each double-dabble shift.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_NIB_W-1:0] nib,
  output logic [BCD_NIB_W-1:0] adj
);

  // Correct one scratch digit ahead of the shift.
  always_comb begin
    adj = add3_adj(nib);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble shift per CLK.
// Optional macro BIN2BCD_AUTO_CONVERT_EN: start automatically in IDLE
// whenever DATA_IN differs from the last accepted value.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W       = 16,
  parameter int BCD_DIGITS  = 5,
  parameter int DISP_DIGITS = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          START,
  input  logic [BIN_W-1:0]              DATA_IN,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [BCD_NIB_W*BCD_DIGITS-1:0] BCD_OUT,
  output logic                          OVF
);

  localparam int SCR_W = BCD_NIB_W * BCD_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  b2b_state_t         state_q, state_d;
  logic [BIN_W-1:0]   bin_q;
  logic [SCR_W-1:0]   scr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SCR_W-1:0]   adj;
  logic [SCR_W-1:0]   scr_next;
  logic [BIN_W-1:0]   bin_next;
  logic               ovf_next;
  logic               start_req;
  logic               accept;
  logic               last_shift;

  genvar g;
  generate
    for (g = 0; g < BCD_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .nib (scr_q[g*BCD_NIB_W +: BCD_NIB_W]),
        .adj (adj[g*BCD_NIB_W +: BCD_NIB_W])
      );
    end
  endgenerate

  assign scr_next = {adj[SCR_W-2:0], bin_q[BIN_W-1]};
  assign bin_next = {bin_q[BIN_W-2:0], 1'b0};

  generate
    if (BCD_DIGITS > DISP_DIGITS) begin : g_ovf
      assign ovf_next = |scr_next[SCR_W-1:BCD_NIB_W*DISP_DIGITS];
    end else begin : g_no_ovf
      assign ovf_next = 1'b0;
    end
  endgenerate

`ifdef BIN2BCD_AUTO_CONVERT_EN
  logic [BIN_W-1:0] last_q;

  // Remember the last accepted word so a change can trigger a conversion.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      last_q <= '0;
    else if (accept) last_q <= DATA_IN;
  end

  assign start_req = START | (DATA_IN != last_q);
`else
  assign start_req = START;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode, accept/finish strobes and BUSY.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    last_shift = 1'b0;
    BUSY       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        BUSY = 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          last_shift = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift datapath, iteration counter and registered result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      BCD_OUT <= '0;
      OVF     <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= last_shift;
      if (accept) begin
        bin_q <= DATA_IN;
        scr_q <= '0;
        cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        bin_q <= bin_next;
        scr_q <= scr_next;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // The last shift's result goes straight to the output register.
      if (last_shift) begin
        BCD_OUT <= scr_next;
        OVF     <= ovf_next;
      end
    end
  end

endmodule
